// File: rtl/mem_stage_ctrl.sv
// +--------------------------------------------------------------------------+
// | Module  : mem_stage_ctrl                                                  |
// | Brief   : Load/store controller between the ALU stage and word-wide data  |
// |           memory (req/ack). Byte stores are done as read-modify-write.    |
// |           Optional macro MEM_ALIGN_CHECK_EN adds misaligned-word trapping.|
// | Revision: 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module mem_stage_ctrl #(
  parameter int unsigned ADDR_W        = 10,
  parameter logic        SIGN_EXT_BYTE = 1'b0
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic [31:0]       ALU_out,
  input  logic [31:0]       RF_B,
  input  logic              Mem_WrEn,
  input  logic              ByteOp,
  output logic              Busy,
  output logic              Done,
  output logic [31:0]       MEM_out,
  output logic              Mem_req,
  output logic              Mem_we,
  output logic [ADDR_W-1:0] Mem_addr,
  output logic [31:0]       Mem_wdata,
  input  logic              Mem_ack,
`ifdef MEM_ALIGN_CHECK_EN
  input  logic [31:0]       Mem_rdata,
  output logic              Misaligned
`else
  input  logic [31:0]       Mem_rdata
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W+1:0] addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic              store_q, store_d;
  logic              byte_q, byte_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       mem_out_q, mem_out_d;
`ifdef MEM_ALIGN_CHECK_EN
  logic              misaligned_q, misaligned_d;
`endif

  logic [7:0]  rd_lane;
  logic [31:0] load_word;
  logic [31:0] merge_word;

  // Upper address bits beyond the memory size are intentionally dropped.
  logic unused_alu_hi;
  assign unused_alu_hi = &{1'b0, ALU_out[31:ADDR_W+2]};

  // Lane select and read-modify-write merge, little-endian byte order.
  always_comb begin
    rd_lane    = Mem_rdata[8*addr_q[1:0] +: 8];
    merge_word = Mem_rdata;
    merge_word[8*addr_q[1:0] +: 8] = data_q[7:0];
    if (!byte_q) begin
      load_word = Mem_rdata;
    end else if (SIGN_EXT_BYTE) begin
      load_word = {{24{rd_lane[7]}}, rd_lane};
    end else begin
      load_word = {24'd0, rd_lane};
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    data_d    = data_q;
    store_d   = store_q;
    byte_d    = byte_q;
    wdata_d   = wdata_q;
    mem_out_d = mem_out_q;
`ifdef MEM_ALIGN_CHECK_EN
    misaligned_d = misaligned_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          addr_d  = ALU_out[ADDR_W+1:0];
          data_d  = RF_B;
          store_d = Mem_WrEn;
          byte_d  = ByteOp;
`ifdef MEM_ALIGN_CHECK_EN
          if (!ByteOp && (ALU_out[1:0] != 2'b00)) begin
            state_d      = S_DONE;
            misaligned_d = 1'b1;
          end else
`endif
          if (Mem_WrEn && !ByteOp) begin
            state_d = S_WR;
            wdata_d = RF_B;
          end else begin
            state_d = S_RD;
          end
        end
      end
      S_RD: begin
        if (Mem_ack) begin
          if (store_q) begin
            wdata_d = merge_word;
            state_d = S_WR;
          end else begin
            mem_out_d = load_word;
            state_d   = S_DONE;
          end
        end
      end
      S_WR: begin
        if (Mem_ack) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
`ifdef MEM_ALIGN_CHECK_EN
        misaligned_d = 1'b0;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      data_q    <= '0;
      store_q   <= 1'b0;
      byte_q    <= 1'b0;
      wdata_q   <= '0;
      mem_out_q <= '0;
`ifdef MEM_ALIGN_CHECK_EN
      misaligned_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      store_q   <= store_d;
      byte_q    <= byte_d;
      wdata_q   <= wdata_d;
      mem_out_q <= mem_out_d;
`ifdef MEM_ALIGN_CHECK_EN
      misaligned_q <= misaligned_d;
`endif
    end
  end

  assign Busy      = (state_q != S_IDLE);
  assign Done      = (state_q == S_DONE);
  assign Mem_req   = (state_q == S_RD) || (state_q == S_WR);
  assign Mem_we    = (state_q == S_WR);
  assign Mem_addr  = addr_q[ADDR_W+1:2];
  assign Mem_wdata = wdata_q;
  assign MEM_out   = mem_out_q;
`ifdef MEM_ALIGN_CHECK_EN
  assign Misaligned = misaligned_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_stage_ctrl.sv
// +--------------------------------------------------------------------------+
// | Module  : tb_mem_stage_ctrl                                               |
// | Brief   : Scoreboard bench for mem_stage_ctrl with a wait-state memory.   |
// | Revision: 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_mem_stage_ctrl;

  localparam int unsigned ADDR_W        = 10;
  localparam logic        SIGN_EXT_BYTE = 1'b0;

  logic              Clk = 1'b0;
  logic              Reset, Start, Mem_WrEn, ByteOp, Mem_ack;
  logic [31:0]       ALU_out, RF_B, Mem_rdata;
  logic              Busy, Done, Mem_req, Mem_we;
  logic [31:0]       MEM_out, Mem_wdata;
  logic [ADDR_W-1:0] Mem_addr;
`ifdef MEM_ALIGN_CHECK_EN
  logic              Misaligned;
`endif

  mem_stage_ctrl #(.ADDR_W(ADDR_W), .SIGN_EXT_BYTE(SIGN_EXT_BYTE)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .ALU_out(ALU_out), .RF_B(RF_B),
    .Mem_WrEn(Mem_WrEn), .ByteOp(ByteOp), .Busy(Busy), .Done(Done),
    .MEM_out(MEM_out), .Mem_req(Mem_req), .Mem_we(Mem_we), .Mem_addr(Mem_addr),
    .Mem_wdata(Mem_wdata), .Mem_ack(Mem_ack),
`ifdef MEM_ALIGN_CHECK_EN
    .Mem_rdata(Mem_rdata), .Misaligned(Misaligned)
`else
    .Mem_rdata(Mem_rdata)
`endif
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [31:0] mem_out;
    int          writes;
    logic [31:0] wdata;
    int          waddr;
    int          ack_addr;
    int          lat;
    logic        mis;
    int          start_cyc;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [31:0] mem [0:(1<<ADDR_W)-1];
  int          wait_cfg = 0;
  int          wait_cnt = 0;
  logic        spurious_ack = 1'b0;
  int          wr_count = 0;
  int          wr_mark = 0;
  logic [31:0] last_wdata = '0;
  int          last_waddr = -1;
  int          last_ack_addr = -1;
  logic        prev_req = 1'b0, prev_ack = 1'b0, prev_we = 1'b0;
  logic [ADDR_W-1:0] prev_addr = '0;
  logic [31:0] prev_wdata = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge Clk) cyc <= cyc + 1;

  // Memory model: acks after wait_cfg stalled cycles per request phase.
  always @(negedge Clk) begin
    if (Mem_req) begin
      if (prev_req && !prev_ack) begin
        check("stable_addr", 32'(Mem_addr), 32'(prev_addr));
        check("stable_we", 32'(Mem_we), 32'(prev_we));
        check("stable_wdata", Mem_wdata, prev_wdata);
      end
      if (wait_cnt >= wait_cfg) begin
        Mem_ack       = 1'b1;
        Mem_rdata     = mem[Mem_addr];
        last_ack_addr = int'(Mem_addr);
        if (Mem_we) begin
          mem[Mem_addr] = Mem_wdata;
          wr_count++;
          last_wdata = Mem_wdata;
          last_waddr = int'(Mem_addr);
        end
        wait_cnt = 0;
      end else begin
        Mem_ack   = 1'b0;
        Mem_rdata = 32'hBAD0BAD0;
        wait_cnt++;
      end
    end else begin
      Mem_ack   = spurious_ack;
      Mem_rdata = 32'hBAD0BAD0;
      wait_cnt  = 0;
    end
    prev_req   = Mem_req;
    prev_ack   = Mem_ack;
    prev_addr  = Mem_addr;
    prev_we    = Mem_we;
    prev_wdata = Mem_wdata;
  end

  // Monitor: every Done pulse must match the oldest expected access.
  always @(negedge Clk) begin
    if (Done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got Done=1 expected no access pending");
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("mem_out", MEM_out, e.mem_out);
        check("write_count", 32'(wr_count - wr_mark), 32'(e.writes));
        check("ack_addr", 32'(last_ack_addr), 32'(e.ack_addr));
        check("latency", 32'(cyc - e.start_cyc), 32'(e.lat));
        if (e.writes > 0) begin
          check("wdata", last_wdata, e.wdata);
          check("waddr", 32'(last_waddr), 32'(e.waddr));
        end
`ifdef MEM_ALIGN_CHECK_EN
        check("misaligned", 32'(Misaligned), 32'(e.mis));
`endif
      end
      wr_mark = wr_count;
    end
  end

  task automatic start_access(input logic [31:0] a, input logic [31:0] d,
                              input logic we, input logic bt, input int waits);
    @(negedge Clk);
    wait_cfg      = waits;
    last_ack_addr = -1;
    ALU_out  = a;
    RF_B     = d;
    Mem_WrEn = we;
    ByteOp   = bt;
    Start    = 1'b1;
  endtask

  task automatic wait_idle();
    @(negedge Clk);
    Start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clk);
      if (!Busy && sb.size() == 0) return;
    end
    checks++;
    errors++;
    $display("FAIL timeout: got Busy=%0b pending=%0d expected idle", Busy, sb.size());
    sb.delete();
  endtask

  task automatic access(input logic [31:0] a, input logic [31:0] d, input logic we,
                        input logic bt, input int waits, input logic [31:0] eo,
                        input int ew, input logic [31:0] ewd, input int ewa,
                        input int eaa, input int lat, input logic mis);
    exp_t e;
    start_access(a, d, we, bt, waits);
    e.mem_out = eo; e.writes = ew; e.wdata = ewd; e.waddr = ewa;
    e.ack_addr = eaa; e.lat = lat; e.mis = mis; e.start_cyc = cyc;
    sb.push_back(e);
    wait_idle();
  endtask

  initial begin
    logic [31:0] lb3, lb2, t7_out;
    int          t7_ack, t7_lat;
    logic        t7_mis;
    lb3 = SIGN_EXT_BYTE ? 32'hFFFFFF80 : 32'h00000080;
    lb2 = SIGN_EXT_BYTE ? 32'hFFFFFFFF : 32'h000000FF;
`ifdef MEM_ALIGN_CHECK_EN
    t7_out = 32'hCAFEF00D; t7_ack = -1; t7_lat = 1; t7_mis = 1'b1;
`else
    t7_out = 32'h0A0B0C0D; t7_ack = 9;  t7_lat = 2; t7_mis = 1'b0;
`endif
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
    Reset = 1'b1; Start = 1'b0; ALU_out = '0; RF_B = '0; Mem_WrEn = 1'b0; ByteOp = 1'b0;
    Mem_ack = 1'b0; Mem_rdata = '0;
    repeat (3) @(negedge Clk);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_done", 32'(Done), 32'd0);
    check("rst_req", 32'(Mem_req), 32'd0);
    check("rst_we", 32'(Mem_we), 32'd0);
    check("rst_mem_out", MEM_out, 32'd0);
    check("rst_addr", 32'(Mem_addr), 32'd0);
    check("rst_wdata", Mem_wdata, 32'd0);
`ifdef MEM_ALIGN_CHECK_EN
    check("rst_misaligned", 32'(Misaligned), 32'd0);
`endif
    Reset = 1'b0;

    mem[4] = 32'hDEADBEEF;
    access(32'h10, 32'h0, 1'b0, 1'b0, 2, 32'hDEADBEEF, 0, 32'h0, -1, 4, 4, 1'b0);
    access(32'h20, 32'h12345678, 1'b1, 1'b0, 0, 32'hDEADBEEF, 1, 32'h12345678, 8, 8, 2, 1'b0);
    mem[8] = 32'h11223344;
    access(32'h21, 32'hAA, 1'b1, 1'b1, 0, 32'hDEADBEEF, 1, 32'h1122AA44, 8, 8, 3, 1'b0);
    mem[8] = 32'h80FFFFFF;
    access(32'h23, 32'h0, 1'b0, 1'b1, 0, lb3, 0, 32'h0, -1, 8, 2, 1'b0);
    access(32'h22, 32'h0, 1'b0, 1'b1, 0, lb2, 0, 32'h0, -1, 8, 2, 1'b0);
    mem[0] = 32'hCAFEF00D;
    access(32'h1000, 32'h0, 1'b0, 1'b0, 0, 32'hCAFEF00D, 0, 32'h0, -1, 0, 2, 1'b0);
    mem[9] = 32'h0A0B0C0D;
    access(32'h26, 32'h0, 1'b0, 1'b0, 0, t7_out, 0, 32'h0, -1, t7_ack, t7_lat, t7_mis);
    mem[12] = 32'h0;
    access(32'h33, 32'hFFFFFF5A, 1'b1, 1'b1, 1, t7_out, 1, 32'h5A000000, 12, 12, 5, 1'b0);

    // Spurious acks in IDLE, then a Start pulse while busy: one load only.
    @(negedge Clk); spurious_ack = 1'b1;
    repeat (2) @(negedge Clk);
    spurious_ack = 1'b0;
    mem[4] = 32'h13579BDF;
    begin
      exp_t e;
      start_access(32'h10, 32'h0, 1'b0, 1'b0, 3);
      e.mem_out = 32'h13579BDF; e.writes = 0; e.wdata = 0; e.waddr = -1;
      e.ack_addr = 4; e.lat = 5; e.mis = 1'b0; e.start_cyc = cyc;
      sb.push_back(e);
      @(negedge Clk); Start = 1'b0;
      @(negedge Clk);
      ALU_out = 32'h40; RF_B = 32'h55; Mem_WrEn = 1'b1; Start = 1'b1;
      @(negedge Clk); Start = 1'b0;
      wait_idle();
    end
    repeat (3) @(negedge Clk);

    access(32'h10, 32'h0F0F0F0F, 1'b1, 1'b0, 2, 32'h13579BDF, 1, 32'h0F0F0F0F, 4, 4, 4, 1'b0);

    // Reset while RD is stalled: request drops, no Done follows.
    start_access(32'h10, 32'h0, 1'b0, 1'b0, 20);
    @(negedge Clk); Start = 1'b0;
    @(negedge Clk);
    check("rd_stalled_req", 32'(Mem_req), 32'd1);
    Reset = 1'b1;
    @(negedge Clk);
    check("abort_req", 32'(Mem_req), 32'd0);
    check("abort_busy", 32'(Busy), 32'd0);
    check("abort_done", 32'(Done), 32'd0);
    check("abort_mem_out", MEM_out, 32'd0);
    Reset = 1'b0;
    repeat (5) @(negedge Clk);

    access(32'h10, 32'h0, 1'b0, 1'b0, 0, 32'h0F0F0F0F, 0, 32'h0, -1, 4, 2, 1'b0);

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL leftover: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
